// File: rtl/dec_scan_sequencer.sv
// Sequential front end for a 4-to-16 decoder.
// Walks sel over the set bits of a latched 16-bit mask, holding each enabled index
// for DWELL cycles. Supports free-run and single-sweep modes.
// Optional feature: define SEL_GAP_EN to insert a one-cycle sel_en=0 gap before each
// new index is enabled (break-before-make on the decoder outputs).
module dec_scan_sequencer #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [15:0] mask,
  output logic [3:0]  sel,
  output logic        sel_en,
  output logic        busy,
  output logic        sweep_done,
  output logic        err
);

  localparam logic [DWELL_W-1:0] DwellLoad = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StGap
  } state_e;

  state_e             state;
  logic [DWELL_W-1:0] cnt;
  logic [15:0]        mask_q;
  logic               mode_q;

  logic [3:0]         nxt;
  logic [3:0]         idx;
  logic               found;
  logic               wrap;

  // Lowest set bit of the incoming mask; first index of a new scan.
  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Next set bit of the latched mask searching upward from sel+1, wrapping 15 -> 0.
  // The 16th probe lands back on sel itself, covering the single-bit mask case.
  always_comb begin
    nxt   = sel;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = sel + 4'(k);
      if (!found && mask_q[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = (nxt <= sel);
  end

  // Scan FSM with registered outputs; stop takes priority over any advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= '0;
      mask_q     <= '0;
      mode_q     <= 1'b0;
      sel        <= '0;
      sel_en     <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        StIdle: begin
          if (start && !stop) begin
            if (mask == 16'h0000) begin
              err <= 1'b1;
            end else begin
              state  <= StScan;
              mask_q <= mask;
              mode_q <= mode;
              sel    <= lowest_set(mask);
              cnt    <= DwellLoad;
              sel_en <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        StScan: begin
          if (stop) begin
            state  <= StIdle;
            sel_en <= 1'b0;
            busy   <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (wrap && mode_q) begin
            // Single sweep ends: sel keeps the last index.
            state      <= StIdle;
            sel_en     <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            sweep_done <= wrap;
            sel        <= nxt;
            cnt        <= DwellLoad;
`ifdef SEL_GAP_EN
            state      <= StGap;
            sel_en     <= 1'b0;
`endif
          end
        end
        StGap: begin
          if (stop) begin
            state  <= StIdle;
            sel_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            state  <= StScan;
            sel_en <= 1'b1;
          end
        end
        default: begin
          state  <= StIdle;
          sel_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Directed self-checking bench for dec_scan_sequencer.
// Three instances share all inputs and differ only in DWELL (4, 2, 3).
module tb_dec_scan_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        mode;
  logic [15:0] mask;

  logic [3:0] sel4, sel2, sel3;
  logic       en4, en2, en3;
  logic       busy4, busy2, busy3;
  logic       sd4, sd2, sd3;
  logic       err4, err2, err3;

  int errors = 0;
  int checks = 0;

  dec_scan_sequencer #(.DWELL(4), .DWELL_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel(sel4), .sel_en(en4), .busy(busy4), .sweep_done(sd4), .err(err4)
  );

  dec_scan_sequencer #(.DWELL(2), .DWELL_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel(sel2), .sel_en(en2), .busy(busy2), .sweep_done(sd2), .err(err2)
  );

  dec_scan_sequencer #(.DWELL(3), .DWELL_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel(sel3), .sel_en(en3), .busy(busy3), .sweep_done(sd3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return every instance to IDLE.
  task automatic settle();
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 16'h0000;
    step();
    step();
    got = {sel4, en4, busy4, sd4, err4};
    exp = 8'h00;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_u4: got %h want %h", got, exp);
    end
    got = {sel2, en2, busy2, sd2, err2};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_u2: got %h want %h", got, exp);
    end
    got = {sel3, en3, busy3, sd3, err3};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_u3: got %h want %h", got, exp);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy4 !== 1'b0 || en4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b en=%b want 0 0", busy4, en4);
    end
  endtask

  // DWELL=4, mask 0x0013, mode=1: 0,1,4 each for 4 cycles, then IDLE with sweep_done.
  task automatic test_single_sweep();
    logic [6:0] got, exp;
    logic [3:0] es;
    mode = 1'b1; mask = 16'h0013; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k < 4) es = 4'd0;
      else if (k < 8) es = 4'd1;
      else es = 4'd4;
      if (k < 12) exp = {es, 3'b110};
      else if (k == 12) exp = {4'd4, 3'b001};
      else exp = {4'd4, 3'b000};
      got = {sel4, en4, busy4, sd4};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_sweep k=%0d: {sel,en,busy,sd} got %h want %h", k, got, exp);
      end
      step();
    end
    settle();
  endtask

  // DWELL=2, mask 0x8001, free-run, then stop during the hold of 15.
  task automatic test_free_run();
    logic [6:0] got, exp;
    mode = 1'b0; mask = 16'h8001; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      exp = {(((k / 2) % 2) == 1) ? 4'd15 : 4'd0, 2'b11, (k >= 2 && (k % 4) == 0)};
      got = {sel2, en2, busy2, sd2};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL free_run k=%0d: {sel,en,busy,sd} got %h want %h", k, got, exp);
      end
      if (k < 10) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    got = {sel2, en2, busy2, sd2};
    exp = {4'd15, 3'b000};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL stop_mid_hold: {sel,en,busy,sd} got %h want %h", got, exp);
    end
    step();
    checks++;
    if (sd2 !== 1'b0 || en2 !== 1'b0) begin
      errors++;
      $display("FAIL stop_after: sd=%b en=%b want 0 0", sd2, en2);
    end
    settle();
  endtask

  // start with an empty mask: one-cycle err, no scan.
  task automatic test_err();
    mask = 16'h0000; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({err4, busy4, en4} !== 3'b100) begin
      errors++;
      $display("FAIL err_pulse: {err,busy,en} got %b want 100", {err4, busy4, en4});
    end
    checks++;
    if (err2 !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse_u2: got %b want 1", err2);
    end
    step();
    checks++;
    if ({err4, busy4, en4} !== 3'b000) begin
      errors++;
      $display("FAIL err_clear: {err,busy,en} got %b want 000", {err4, busy4, en4});
    end
    settle();
  endtask

  // DWELL=3, single-bit mask 0x0020: sel stays 5, sweep_done every 3 cycles.
  task automatic test_single_bit();
    logic [6:0] got, exp;
    mode = 1'b0; mask = 16'h0020; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {4'd5, 2'b11, (k != 0 && (k % 3) == 0)};
      got = {sel3, en3, busy3, sd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_bit k=%0d: {sel,en,busy,sd} got %h want %h", k, got, exp);
      end
      step();
    end
    settle();
  endtask

  // DWELL=4 free-run 0x0013; mask and start changes mid-scan are ignored; then reset.
  task automatic test_mask_ignore_and_reset();
    logic [6:0] got, exp;
    logic [3:0] es;
    logic [7:0] got_r;
    mode = 1'b0; mask = 16'h0013; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k == 2) mask = 16'hFFFF;
      if (k == 5) start = 1'b1;
      case ((k / 4) % 3)
        0: es = 4'd0;
        1: es = 4'd1;
        default: es = 4'd4;
      endcase
      exp = {es, 2'b11, (k != 0 && (k % 12) == 0)};
      got = {sel4, en4, busy4, sd4};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mask_ignore k=%0d: {sel,en,busy,sd} got %h want %h", k, got, exp);
      end
      step();
    end
    rst_n = 1'b0; start = 1'b0; mask = 16'h0000;
    step();
    got_r = {sel4, en4, busy4, sd4, err4};
    checks++;
    if (got_r !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_scan: got %h want 00", got_r);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({en4, busy4, sd4} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_scan_after: {en,busy,sd} got %b want 000", {en4, busy4, sd4});
    end
    settle();
  endtask

  // DWELL=2, mask 0x0006, mode=1; gap cycle before index 2 only when SEL_GAP_EN is set.
  task automatic test_gap();
    logic [6:0] got, exp;
    logic [6:0] tbl [6];
`ifdef SEL_GAP_EN
    tbl[0] = {4'd1, 3'b110};
    tbl[1] = {4'd1, 3'b110};
    tbl[2] = {4'd2, 3'b010};
    tbl[3] = {4'd2, 3'b110};
    tbl[4] = {4'd2, 3'b110};
    tbl[5] = {4'd2, 3'b001};
`else
    tbl[0] = {4'd1, 3'b110};
    tbl[1] = {4'd1, 3'b110};
    tbl[2] = {4'd2, 3'b110};
    tbl[3] = {4'd2, 3'b110};
    tbl[4] = {4'd2, 3'b001};
    tbl[5] = {4'd2, 3'b000};
`endif
    mode = 1'b1; mask = 16'h0006; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp = tbl[k];
      got = {sel2, en2, busy2, sd2};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL gap k=%0d: {sel,en,busy,sd} got %h want %h", k, got, exp);
      end
      step();
    end
    settle();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 16'h0000;
    test_reset();
    test_single_sweep();
    test_free_run();
    test_err();
    test_single_bit();
    test_mask_ignore_and_reset();
    test_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_scan_sequencer.md
Name: dec_scan_sequencer

Overview:
- Sequential front end for the 4-to-16 decoder.
- Walks a 4-bit select index over the enabled slots of a 16-bit mask.
- Holds each slot for a programmable number of cycles; drives the decoder's en and in inputs directly.
- Supports free-running repeated scanning and single-sweep operation, with start/stop control and sweep-complete signalling.

Parameters:
- DWELL, 4: cycles each enabled index is presented with sel_en=1. Legal range 1..255.
- DWELL_W, 8: width of the internal dwell counter. Must satisfy DWELL <= 2^DWELL_W - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin scanning. Sampled only in IDLE.
- stop  input  1  abort scan. Return to IDLE.
- mode  input  1  0 = free-run (repeat sweeps), 1 = single sweep. Latched with start.
- mask  input  16  bit i=1 means index i is visited. Latched with start.
- sel  output  4  index to the decoder's in.
- sel_en  output  1  enable to the decoder's en.
- busy  output  1  high while not in IDLE.
- sweep_done  output  1  one-cycle pulse after the last enabled index of a sweep completes.
- err  output  1  one-cycle pulse when start arrives with mask==0.

Behaviour:
- Reset is synchronous and active-low. With rst_n=0 at a rising edge, all of the following are 0: sel, sel_en, busy, sweep_done, err, state (IDLE), dwell counter, latched mask, latched mode.
- Reset mid-scan acts at the next edge. sel_en is 0 in the following cycle; no sweep_done pulse.
- States:
  - IDLE: sel_en=0, busy=0. sel holds its last value (0 after reset).
  - SCAN: sel_en=1 (except during a gap cycle, see optional feature), busy=1.
- IDLE -> SCAN:
  - Condition: start=1, stop=0, mask!=0 at an edge.
  - At that edge, latch mask and mode, set sel to the lowest set bit of mask, and load the dwell counter with DWELL-1.
  - sel_en=1 from the next cycle. Start-to-enable latency is 1 cycle.
- start=1 with mask==0 in IDLE: stay in IDLE and pulse err for 1 cycle.
- start in SCAN is ignored. The latched mask and mode do not change.
- Dwell:
  - While the counter is nonzero, decrement it each cycle; sel is held.
  - When the counter is 0, advance sel to the next set bit of the latched mask, searching from sel+1 upward with wrap 15 -> 0, and reload the counter with DWELL-1.
- Wrap detection:
  - An advance whose next index is <= the current sel ends a sweep. This includes the single-bit mask case, where next == current.
  - sweep_done is asserted for the 1 cycle after that advance edge.
- End of sweep:
  - mode=0: continue scanning from the wrapped index.
  - mode=1: go to IDLE at the wrap edge instead of advancing. sel keeps the last index, sel_en=0, busy=0; sweep_done still pulses.
- stop=1 in SCAN: go to IDLE at that edge. Next cycle sel_en=0, no sweep_done. stop has priority over a simultaneous advance or wrap.
- start=1 and stop=1 together in IDLE: stay in IDLE.
- DWELL=1: the index changes every cycle; sel_en stays 1 continuously.
- Changes to the mask input during SCAN have no effect.
- Invariant: sel_en=1 only while sel is a set bit of the latched mask. At most one decoder output is active per cycle.

Optional Feature:
- Macro: SEL_GAP_EN.
- Defined: every advance inserts one gap cycle with sel_en=0 before the new index is enabled (break-before-make on the decoder outputs).
  - sel updates during the gap cycle.
  - Each index period is DWELL+1 cycles.
  - sweep_done timing is unchanged: it pulses in the gap cycle that follows the wrap.
  - stop during a gap cycle goes to IDLE as normal.
- Undefined: no gap cycles; behaviour is exactly as described above.

Test Plan:
- Reset, then start=1, mode=1, mask=16'h0013, DWELL=4 -> sel = 0, 1, 4, each for 4 cycles with sel_en=1. sweep_done pulses once; busy drops; sel_en=0 afterwards.
- mode=0, mask=16'h8001, DWELL=2 -> sel sequence 0,0,15,15,0,0,15,15… sweep_done pulses each time 15 -> 0. Assert stop mid-hold of 15 -> sel_en=0 the next cycle, no sweep_done.
- mask=16'h0000 with start -> err pulses for 1 cycle; busy stays 0; sel_en stays 0.
- mode=0, mask=16'h0020, DWELL=3 -> sel stays 5 with sel_en=1 continuously; sweep_done pulses every 3 cycles.
- Change mask to 16'hFFFF mid-scan, then assert start mid-scan -> sequence unchanged. Assert rst_n=0 mid-scan -> next cycle all outputs are 0.
- SEL_GAP_EN defined, mask=16'h0006, DWELL=2, mode=1 -> sel_en pattern 1,1,0,1,1 then 0 (IDLE). sel = 1 then 2; sweep_done pulses in the final cycle.
